// File: rtl/file_port_arbiter.sv
// Arbitrates NCLIENTS onto a 1W/2R register file: one round-robin write pool and two round-robin read slots; reads respond one cycle after grant.
// Ready is combinational and gated by reset. FILE_PORT_ARBITER_BYPASS_EN forwards same-cycle write data to a matching read.
module file_port_arbiter #(
  parameter int NCLIENTS = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCLIENTS-1:0]          req_valid_in,
  input  logic [NCLIENTS-1:0]          req_write_in,
  input  logic [NCLIENTS*ADDR_W-1:0]   req_addr_in,
  input  logic [NCLIENTS*DATA_W-1:0]   req_data_in,
  output logic [NCLIENTS-1:0]          req_ready_out,
  output logic [NCLIENTS-1:0]          rsp_valid_out,
  output logic [NCLIENTS*DATA_W-1:0]   rsp_data_out,
  output logic [ADDR_W-1:0]            file_write_addr_out,
  output logic                         file_write_out,
  output logic [DATA_W-1:0]            file_write_data_out,
  output logic [ADDR_W-1:0]            file_read_addr0_out,
  output logic [ADDR_W-1:0]            file_read_addr1_out,
  output logic                         file_read_out,
  input  logic [DATA_W-1:0]            file_read_data0_in,
  input  logic [DATA_W-1:0]            file_read_data1_in
);

  localparam int IDX_W = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

  logic [IDX_W-1:0]        wr_ptr, rd_ptr;
  logic [IDX_W-1:0]        wr_idx, rd0_idx, rd1_idx, rd_last;
  logic                    wr_vld, rd0_vld, rd1_vld;
  logic [NCLIENTS-1:0]     wr_gnt, rd0_gnt, rd1_gnt;
  logic [DATA_W-1:0]       rd0_dat, rd1_dat;
  logic [NCLIENTS-1:0]     rsp_vld_q;
  logic [NCLIENTS*DATA_W-1:0] rsp_dat_q;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int offs);
    int j;
    j = int'(base) + offs;
    if (j >= NCLIENTS) j = j - NCLIENTS;
    return IDX_W'(j);
  endfunction

  // Both pools scan from their own pointer; reset blocks every grant.
  always_comb begin
    wr_vld  = 1'b0;
    wr_idx  = '0;
    rd0_vld = 1'b0;
    rd0_idx = '0;
    rd1_vld = 1'b0;
    rd1_idx = '0;
    if (!reset) begin
      for (int k = 0; k < NCLIENTS; k++) begin
        if (!wr_vld && req_valid_in[rr_idx(wr_ptr, k)] && req_write_in[rr_idx(wr_ptr, k)]) begin
          wr_vld = 1'b1;
          wr_idx = rr_idx(wr_ptr, k);
        end
        if (req_valid_in[rr_idx(rd_ptr, k)] && !req_write_in[rr_idx(rd_ptr, k)]) begin
          if (!rd0_vld) begin
            rd0_vld = 1'b1;
            rd0_idx = rr_idx(rd_ptr, k);
          end else if (!rd1_vld) begin
            rd1_vld = 1'b1;
            rd1_idx = rr_idx(rd_ptr, k);
          end
        end
      end
    end
  end

  always_comb begin
    wr_gnt  = '0;
    rd0_gnt = '0;
    rd1_gnt = '0;
    if (wr_vld)  wr_gnt[wr_idx]   = 1'b1;
    if (rd0_vld) rd0_gnt[rd0_idx] = 1'b1;
    if (rd1_vld) rd1_gnt[rd1_idx] = 1'b1;
  end

  assign rd_last       = rd1_vld ? rd1_idx : rd0_idx;
  assign req_ready_out = wr_gnt | rd0_gnt | rd1_gnt;

  assign file_write_out      = wr_vld;
  assign file_write_addr_out = wr_vld ? req_addr_in[int'(wr_idx)*ADDR_W +: ADDR_W] : '0;
  assign file_write_data_out = wr_vld ? req_data_in[int'(wr_idx)*DATA_W +: DATA_W] : '0;
  assign file_read_out       = rd0_vld;
  assign file_read_addr0_out = rd0_vld ? req_addr_in[int'(rd0_idx)*ADDR_W +: ADDR_W] : '0;
  assign file_read_addr1_out = rd1_vld ? req_addr_in[int'(rd1_idx)*ADDR_W +: ADDR_W] : '0;

`ifdef FILE_PORT_ARBITER_BYPASS_EN
  assign rd0_dat = (wr_vld && rd0_vld && file_read_addr0_out == file_write_addr_out)
                   ? file_write_data_out : file_read_data0_in;
  assign rd1_dat = (wr_vld && rd1_vld && file_read_addr1_out == file_write_addr_out)
                   ? file_write_data_out : file_read_data1_in;
`else
  assign rd0_dat = file_read_data0_in;
  assign rd1_dat = file_read_data1_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_vld_q <= '0;
      rsp_dat_q <= '0;
    end else begin
      if (wr_vld)  wr_ptr <= rr_idx(wr_idx, 1);
      if (rd0_vld) rd_ptr <= rr_idx(rd_last, 1);
      rsp_vld_q <= rd0_gnt | rd1_gnt;
      for (int i = 0; i < NCLIENTS; i++) begin
        if (rd0_gnt[i])      rsp_dat_q[i*DATA_W +: DATA_W] <= rd0_dat;
        else if (rd1_gnt[i]) rsp_dat_q[i*DATA_W +: DATA_W] <= rd1_dat;
      end
    end
  end

  // A response pending when reset rises is dropped rather than presented.
  assign rsp_valid_out = rsp_vld_q & {NCLIENTS{~reset}};
  assign rsp_data_out  = rsp_dat_q;

endmodule
